cmos_rgb565_packer: RTL and testbench
=====================================

# cmos_rgb565_packer

Pixel-domain capture stage that sits between the OV5640 parallel port and the SDRAM frame buffer write FIFO. It samples the 8-bit sensor bus under HREF/VSYNC and packs byte pairs into 16-bit RGB565 words. It emits a one-cycle write strobe per pixel and a frame-valid level that the SDRAM controller uses as its address-restart signal. It discards settling frames after configuration and flags malformed lines and frames.

## Interface
- `FRAME_SKIP`, default 10: complete frames discarded after `init_done` before output starts.
- `H_PIXELS`, default 480: expected pixels per line.
- `V_LINES`, default 272: expected lines per frame.
- `VS_ACTIVE_HIGH`, default 1: VSYNC polarity (1 = high during vertical blank).
- `clk`  in  1  sensor pixel clock (CMOS_PCLK); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `init_done`  in  1  sensor configured AND SDRAM initialised; level.
- `cmos_vsync`  in  1  sensor VSYNC.
- `cmos_href`  in  1  sensor HREF, high during active bytes.
- `cmos_data`  in  8  sensor byte bus.
- `pix_we`  out  1  one-cycle strobe; `pix_data` valid.
- `pix_data`  out  16  RGB565 word {first byte, second byte}.
- `frame_valid`  out  1  high while an output frame is in progress.
- `line_err`  out  1  sticky; a line had a pixel count other than `H_PIXELS`, or an odd byte count.
- `frame_err`  out  1  sticky; a frame had a line count other than `V_LINES`.
- `frame_cnt`  out  16  output frames completed (stats build only).

## Operation
- All sensor inputs are registered once (`vs_q`, `hs_q`, `d_q`). All logic uses the registered copies. `vs_act = vs_q ^ ~VS_ACTIVE_HIGH`.
- The FSM has four states: IDLE, SYNC, SKIP, RUN.
  - IDLE: leaves when `init_done`=1, going to SYNC.
  - SYNC: on the rising edge of `vs_act`, goes to SKIP. If `FRAME_SKIP`=0, it goes directly to RUN.
  - SKIP: counts rising edges of `vs_act`. When the count reaches `FRAME_SKIP`, it goes to RUN.
  - RUN: stays in RUN.
  - Any state: `init_done`=0 goes to IDLE.
- `frame_valid` = (state==RUN) & ~`vs_act`, registered.
- Byte phase:
  - The phase toggles on each cycle with `hs_q`=1 in RUN.
  - Phase 0 latches the high byte.
  - Phase 1 drives `pix_data`={hi, d_q} and `pix_we`=1.
  - The phase is cleared when `hs_q`=0.
- The pixel counter (10 bits) increments per `pix_we`. On the falling edge of `hs_q`:
  - If count≠`H_PIXELS` or phase=1 (odd bytes), set `line_err`. The partial byte is dropped.
  - Increment the line counter (9 bits) and clear the pixel counter.
- On the rising edge of `vs_act` in RUN:
  - If line count≠`V_LINES`, set `frame_err`.
  - Clear the line counter and increment `frame_cnt` (wraps at 0xFFFF).
- Counters saturate at all-ones rather than wrap, so an oversized line still reports an error.
- `pix_we` is never asserted outside RUN or while `vs_act`=1.
- If `init_done` falls mid-line, the FSM enters IDLE on the next cycle. Phase and counters clear, and no partial word is emitted. The error flags hold.

## Timing
- Reset values: `pix_we`=0, `pix_data`=0, `frame_valid`=0, `line_err`=0, `frame_err`=0, `frame_cnt`=0. FSM is in IDLE.
- Latency: the low byte is sampled on the pins at edge k, and `pix_we` is high for the cycle following edge k+1 (2 clocks).
- Throughput: one word per 2 clocks while HREF is high. There is no backpressure; the downstream FIFO must accept every strobe.
- `frame_valid` falls 2 clocks after the pin-level VSYNC assertion and rises 2 clocks after its deassertion.
- Simultaneous HREF fall and VSYNC rise: line accounting is applied before the frame check in the same cycle.
- The error flags clear only on `rst`.

## Configuration
- `CMOS_FRAME_STATS_EN` defined: the line/frame checkers, `line_err`, `frame_err` and `frame_cnt` are built as described.
- Undefined: the checkers and `frame_cnt` are removed and those outputs are tied to 0. Packing, FSM and `frame_valid` are unchanged.

## Structure
- A shared package `cmos_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_SYNC`, `ST_SKIP`, `ST_RUN`);
  - the RGB565 field widths;
  - the counter widths (pixel 10, line 9, frame 16).
- Sub-module `cmos_frame_checker` holds the line/frame counting and sticky flags. It is instantiated only under `CMOS_FRAME_STATS_EN`.

## Test plan
- Reset, then `init_done`=1 with `FRAME_SKIP`=2 and 3 frames of 480×272 → no `pix_we` in frames 1–2; frame 3 yields 480×272 strobes; `frame_cnt`=1; no error flags.
- Byte pair 0xF8,0x1F in RUN → `pix_data`=0xF81F with `pix_we` exactly 2 clocks after the 0x1F sample.
- A line of 481 bytes (odd) → 240 strobes for that line; `line_err`=1 and it stays set across later good frames.
- A frame of 271 lines → `frame_err`=1 at the next VSYNC rise; `line_err` stays 0.
- `init_done` dropped mid-line after 100 pixels → `pix_we` stops within 1 clock and `frame_valid`=0. Re-assert → the FSM waits in SYNC, then skips `FRAME_SKIP` frames again.
- `VS_ACTIVE_HIGH`=0 with an inverted VSYNC stimulus → identical strobe count and `frame_valid` waveform as the default polarity.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and widths for the CMOS RGB565 capture path.
package cmos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SKIP,
        ST_RUN
    } cmos_state_e;

    localparam int R_BITS      = 5;
    localparam int G_BITS      = 6;
    localparam int B_BITS      = 5;
    localparam int RGB_W       = R_BITS + G_BITS + B_BITS;

    localparam int PIX_CNT_W   = 10;
    localparam int LINE_CNT_W  = 9;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/cmos_frame_checker.sv
// Line/frame geometry checker: counts words per line and lines per frame,
// raises sticky error flags and counts completed output frames.
module cmos_frame_checker
    import cmos_pkg::*;
#(
    parameter int H_PIXELS = 480,
    parameter int V_LINES  = 272
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pix_emit,
    input  logic                   hs_fall,
    input  logic                   odd_phase,
    input  logic                   vs_rise,
    output logic                   line_err,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam logic [PIX_CNT_W-1:0]  H_EXP = PIX_CNT_W'(H_PIXELS);
    localparam logic [LINE_CNT_W-1:0] V_EXP = LINE_CNT_W'(V_LINES);

    logic [PIX_CNT_W-1:0]  pix_cnt_reg;
    logic [LINE_CNT_W-1:0] line_cnt_reg;
    logic [LINE_CNT_W-1:0] line_cnt_next;

    // A line ending on the same cycle as the frame boundary still counts
    // toward the frame being closed.
    always_comb begin
        line_cnt_next = line_cnt_reg;
        if (hs_fall && (line_cnt_reg != '1)) begin
            line_cnt_next = line_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else if (!enable) begin
            pix_cnt_reg  <= '0;
            line_cnt_reg <= '0;
        end else begin
            if (hs_fall) begin
                if ((pix_cnt_reg != H_EXP) || odd_phase) begin
                    line_err <= 1'b1;
                end
                pix_cnt_reg <= '0;
            end else if (pix_emit && (pix_cnt_reg != '1)) begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end

            line_cnt_reg <= line_cnt_next;
            if (vs_rise) begin
                if (line_cnt_next != V_EXP) begin
                    frame_err <= 1'b1;
                end
                line_cnt_reg <= '0;
                frame_cnt    <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmos_rgb565_packer.sv
// OV5640 parallel-port capture: skips settling frames, packs byte pairs into
// RGB565 words. Define CMOS_FRAME_STATS_EN to build the line/frame checker.
module cmos_rgb565_packer
    import cmos_pkg::*;
#(
    parameter int FRAME_SKIP     = 10,
    parameter int H_PIXELS       = 480,
    parameter int V_LINES        = 272,
    parameter int VS_ACTIVE_HIGH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_done,
    input  logic                   cmos_vsync,
    input  logic                   cmos_href,
    input  logic [7:0]             cmos_data,
    output logic                   pix_we,
    output logic [RGB_W-1:0]       pix_data,
    output logic                   frame_valid,
    output logic                   line_err,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam logic VS_INV = (VS_ACTIVE_HIGH == 0);
    localparam int   SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);

    logic        vs_q, hs_q, vs_act_d;
    logic [7:0]  d_q;
    logic        vs_act, vs_rise, run, pix_go, emit;
    logic        phase_reg;
    logic [7:0]  hi_reg;
    cmos_state_e state_reg, state_next;
    logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;

    assign vs_act  = vs_q ^ VS_INV;
    assign vs_rise = vs_act & ~vs_act_d;
    assign run     = (state_reg == ST_RUN) && init_done;
    assign pix_go  = run && !vs_act && hs_q;
    assign emit    = pix_go && phase_reg;

    // Input register; vs_q resets to the inactive pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q     <= VS_INV;
            hs_q     <= 1'b0;
            d_q      <= '0;
            vs_act_d <= 1'b0;
        end else begin
            vs_q     <= cmos_vsync;
            hs_q     <= cmos_href;
            d_q      <= cmos_data;
            vs_act_d <= vs_act;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            skip_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            skip_cnt_reg <= skip_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        if (!init_done) begin
            state_next    = ST_IDLE;
            skip_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_SYNC;
                    skip_cnt_next = '0;
                end
                ST_SYNC: begin
                    skip_cnt_next = '0;
                    if (vs_rise) begin
                        state_next = (FRAME_SKIP == 0) ? ST_RUN : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt_reg == SKIP_LAST) begin
                            state_next = ST_RUN;
                        end else begin
                            skip_cnt_next = skip_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_RUN:  state_next = ST_RUN;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Byte pairing; any break in HREF or RUN drops a pending high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_we      <= 1'b0;
            pix_data    <= '0;
            frame_valid <= 1'b0;
            phase_reg   <= 1'b0;
            hi_reg      <= '0;
        end else begin
            pix_we      <= emit;
            frame_valid <= (state_reg == ST_RUN) && !vs_act;
            if (pix_go) begin
                phase_reg <= ~phase_reg;
                if (!phase_reg) begin
                    hi_reg <= d_q;
                end else begin
                    pix_data <= {hi_reg, d_q};
                end
            end else begin
                phase_reg <= 1'b0;
            end
        end
    end

`ifdef CMOS_FRAME_STATS_EN
    logic hs_d, hs_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d <= 1'b0;
        end else begin
            hs_d <= hs_q;
        end
    end

    assign hs_fall = ~hs_q & hs_d;

    cmos_frame_checker #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .enable    (run),
        .pix_emit  (emit),
        .hs_fall   (hs_fall),
        .odd_phase (phase_reg),
        .vs_rise   (vs_rise),
        .line_err  (line_err),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );
`else
    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cmos_rgb565_packer.sv
// Scoreboard bench: frame-level reference model feeds an expected-word queue,
// a negedge monitor pops and compares on every pix_we.
module tb_cmos_rgb565_packer;
    localparam int FS = 2;
    localparam int HP = 16;
    localparam int VL = 4;
`ifdef CMOS_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, init_done, cmos_vsync, cmos_href, cmos_vsync_n;
    logic [7:0]  cmos_data;
    logic        pix_we, frame_valid, line_err, frame_err;
    logic [15:0] pix_data, frame_cnt;
    logic        pix_we_n, frame_valid_n, line_err_n, frame_err_n;
    logic [15:0] pix_data_n, frame_cnt_n;

    assign cmos_vsync_n = ~cmos_vsync;

    cmos_rgb565_packer #(.FRAME_SKIP(FS), .H_PIXELS(HP), .V_LINES(VL), .VS_ACTIVE_HIGH(1)) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cmos_data(cmos_data), .pix_we(pix_we), .pix_data(pix_data),
        .frame_valid(frame_valid), .line_err(line_err), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    cmos_rgb565_packer #(.FRAME_SKIP(FS), .H_PIXELS(HP), .V_LINES(VL), .VS_ACTIVE_HIGH(0)) dut_n (
        .clk(clk), .rst(rst), .init_done(init_done), .cmos_vsync(cmos_vsync_n),
        .cmos_href(cmos_href), .cmos_data(cmos_data), .pix_we(pix_we_n), .pix_data(pix_data_n),
        .frame_valid(frame_valid_n), .line_err(line_err_n), .frame_err(frame_err_n), .frame_cnt(frame_cnt_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit init_m = 1'b0;
    bit in_run = 1'b0;
    int rises = 0;
    int frame_lines = 0;
    int frame_words = 0;
    bit exp_le = 1'b0;
    bit exp_fe = 1'b0;
    int exp_fc = 0;
    int frame_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_we) begin
                if (sb.size() == 0) begin
                    chk("strobe_expected", pix_we, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pix_data", pix_data, e.data);
                    chk("pix_latency", cyc, e.cyc);
                end
            end
            chk("polarity_match",
                {pix_we_n, pix_data_n, frame_valid_n, line_err_n, frame_err_n, frame_cnt_n},
                {pix_we, pix_data, frame_valid, line_err, frame_err, frame_cnt});
        end
    end

    task automatic tick(input logic vs, input logic hs, input logic [7:0] d);
        @(negedge clk);
        cmos_vsync = vs;
        cmos_href  = hs;
        cmos_data  = d;
    endtask

    task automatic raise_init();
        @(negedge clk);
        init_done   = 1'b1;
        init_m      = 1'b1;
        rises       = 0;
        in_run      = 1'b0;
        frame_lines = 0;
        repeat (4) tick(1'b0, 1'b0, 8'h00);
    endtask

    // drop_at >= 0: init_done falls together with that byte index.
    task automatic line(input int nbytes, input bit special, input int drop_at);
        logic [7:0] b, hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(0, 255));
            if (special && i == 0) b = 8'hF8;
            if (special && i == 1) b = 8'h1F;
            tick(1'b0, 1'b1, b);
            if (i == drop_at) init_done = 1'b0;
            if (drop_at >= 0 && i == drop_at + 1) chk("we_after_drop", pix_we, 1'b0);
            if (i % 2 == 0) begin
                hi = b;
            end else if (in_run && !(drop_at >= 0 && i + 1 >= drop_at)) begin
                sb.push_back('{data: {hi, b}, cyc: cyc + 2});
                frame_words++;
            end
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        if (drop_at >= 0) begin
            init_m = 1'b0;
            in_run = 1'b0;
            rises  = 0;
            chk("fv_after_drop", frame_valid, 1'b0);
        end else if (in_run) begin
            frame_lines++;
            if (nbytes != 2 * HP) exp_le = 1'b1;
        end
    endtask

    task automatic frame(input int nlines, input int odd_line, input bit special, input int drop_line);
        for (int l = 0; l < nlines; l++) begin
            line((l == odd_line) ? 2 * HP + 1 : 2 * HP, special && l == 0,
                 (l == drop_line) ? 21 : -1);
        end
    endtask

    task automatic vblank();
        bit prev_run;
        prev_run = in_run;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("fv_vs_assert_1", frame_valid, prev_run);
        tick(1'b1, 1'b0, 8'h00);
        chk("fv_vs_assert_2", frame_valid, 1'b0);
        if (init_m) rises++;
        if (prev_run) begin
            exp_fc++;
            if (frame_lines != VL) exp_fe = 1'b1;
        end
        frame_lines = 0;
        in_run = init_m && (rises >= FS + 1);
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        chk("fv_vs_release_1", frame_valid, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        chk("fv_vs_release_2", frame_valid, in_run);
        tick(1'b0, 1'b0, 8'h00);
        chk("line_err", line_err, STATS ? exp_le : 1'b0);
        chk("frame_err", frame_err, STATS ? exp_fe : 1'b0);
        chk("frame_cnt", frame_cnt, STATS ? 16'(exp_fc) : 16'h0);
        $display("frame %0d: words=%0d run_next=%0b line_err=%0b frame_err=%0b frame_cnt=%0d",
                 frame_no, frame_words, in_run, line_err, frame_err, frame_cnt);
        frame_no++;
        frame_words = 0;
    endtask

    initial begin
        rst        = 1'b1;
        init_done  = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pix_we", pix_we, 1'b0);
        chk("rst_pix_data", pix_data, 16'h0);
        chk("rst_frame_valid", frame_valid, 1'b0);
        chk("rst_line_err", line_err, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        raise_init();
        // Two settling frames, then the first output frame leads with 0xF8,0x1F.
        vblank(); frame(VL, -1, 1'b0, -1);
        vblank(); frame(VL, -1, 1'b0, -1);
        vblank(); frame(VL, -1, 1'b1, -1);
        vblank();
        // Short frame, then an odd-length line, then a clean frame.
        frame(VL - 1, -1, 1'b0, -1); vblank();
        frame(VL, 1, 1'b0, -1);      vblank();
        frame(VL, -1, 1'b0, -1);     vblank();
        // init_done lost mid-line; re-arm and skip again.
        frame(VL, -1, 1'b0, 1);      vblank();
        raise_init();
        vblank(); frame(VL, -1, 1'b0, -1);
        vblank(); frame(VL, -1, 1'b0, -1);
        vblank(); frame(VL, -1, 1'b0, -1);
        vblank();

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
